// File: rtl/muldiv_ctrl.sv
// Multiply/divide unit controller for the EX stage: one-cycle 32x32 multiply and
// 32-cycle radix-2 restoring divide, with HI/LO results and a pipeline stall request.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned W       = 32;
    localparam int unsigned CW      = 6;
    localparam int unsigned LAST_IT = W - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    acc_hi_q, acc_hi_d;
    logic [W-1:0]    acc_lo_q, acc_lo_d;
    logic [W-1:0]    dvs_q, dvs_d;
    logic            sgn_q, sgn_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;

    logic            accept_c;
    logic            a_neg_c, b_neg_c;
    logic [W-1:0]    mag_a_c, mag_b_c;
    logic [2*W-1:0]  mul_a_c, mul_b_c, prod_c;
    logic [W:0]      shifted_c, diff_c;
    logic [W-1:0]    q_next_c, r_next_c;

    assign accept_c = (state_q == S_IDLE) & start & ~flush;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush annuls the instruction from any state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (!op[1]) begin
                        state_d = S_MUL;
                    end else if (b == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL:  state_d = S_DONE;
            S_DIV:  if (cnt_q == CW'(LAST_IT)) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // Outputs: the new result is visible during the DONE cycle unless flushed
    always_comb begin
        stall = accept_c | (state_q == S_MUL) | (state_q == S_DIV);
        done  = (state_q == S_DONE) & ~flush;
        hi    = done ? acc_hi_q : hi_q;
        lo    = done ? acc_lo_q : lo_q;
    end

    // Arithmetic helpers
    always_comb begin
        a_neg_c   = ~op[0] & a[W-1];
        b_neg_c   = ~op[0] & b[W-1];
        mag_a_c   = a_neg_c ? W'(-a) : a;
        mag_b_c   = b_neg_c ? W'(-b) : b;
        mul_a_c   = {(sgn_q ? {W{acc_lo_q[W-1]}} : {W{1'b0}}), acc_lo_q};
        mul_b_c   = {(sgn_q ? {W{dvs_q[W-1]}} : {W{1'b0}}), dvs_q};
        prod_c    = mul_a_c * mul_b_c;
        shifted_c = {acc_hi_q, acc_lo_q[W-1]};
        diff_c    = shifted_c - {1'b0, dvs_q};
        q_next_c  = {acc_lo_q[W-2:0], ~diff_c[W]};
        r_next_c  = diff_c[W] ? shifted_c[W-1:0] : diff_c[W-1:0];
    end

    // Datapath next-state: acc_hi/acc_lo hold remainder/quotient or the product
    always_comb begin
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        dvs_d    = dvs_q;
        sgn_d    = sgn_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    cnt_d = '0;
                    sgn_d = ~op[0];
                    if (!op[1]) begin
                        acc_lo_d = a;
                        dvs_d    = b;
                    end else if (b == '0) begin
                        acc_hi_d = a;
                        acc_lo_d = '1;
                    end else begin
                        acc_hi_d = '0;
                        acc_lo_d = mag_a_c;
                        dvs_d    = mag_b_c;
                        negq_d   = a_neg_c ^ b_neg_c;
                        negr_d   = a_neg_c;
                    end
                end
            end
            S_MUL: begin
                acc_hi_d = prod_c[2*W-1:W];
                acc_lo_d = prod_c[W-1:0];
            end
            S_DIV: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(LAST_IT)) begin
                    acc_lo_d = negq_q ? W'(-q_next_c) : q_next_c;
                    acc_hi_d = negr_q ? W'(-r_next_c) : r_next_c;
                end else begin
                    acc_lo_d = q_next_c;
                    acc_hi_d = r_next_c;
                end
            end
            S_DONE: begin
                if (!flush) begin
                    hi_d = acc_hi_q;
                    lo_d = acc_lo_q;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            dvs_q    <= '0;
            sgn_q    <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            dvs_q    <= dvs_d;
            sgn_q    <= sgn_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_muldiv_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .stall (stall),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Architectural result and latency (accept cycle to done cycle)
    function automatic void golden(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] gh, output logic [31:0] gl, output int lat);
        longint          sx, sy, sp, sq, sr;
        longint unsigned ux, uy, up, uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        if (o == 2'b00) begin
            sp = sx * sy;
            gh = sp[63:32]; gl = sp[31:0]; lat = 2;
        end else if (o == 2'b01) begin
            up = ux * uy;
            gh = up[63:32]; gl = up[31:0]; lat = 2;
        end else if (y == 32'd0) begin
            gh = x; gl = 32'hFFFF_FFFF; lat = 1;
        end else if (o == 2'b10) begin
            sq = sx / sy; sr = sx % sy;
            gh = sr[31:0]; gl = sq[31:0]; lat = 33;
        end else begin
            uq = ux / uy; ur = ux % uy;
            gh = ur[31:0]; gl = uq[31:0]; lat = 33;
        end
    endfunction

    // Reference model: one in-flight instruction with a cycles-to-done countdown
    bit          m_valid = 1'b0;
    bit          m_busy  = 1'b0;
    int          m_left  = 0;
    logic [31:0] m_pend_hi, m_pend_lo, m_com_hi, m_com_lo;

    always @(posedge clk) begin
        int lat;
        if (rst) begin
            m_valid  = 1'b1;
            m_busy   = 1'b0;
            m_com_hi = 32'd0;
            m_com_lo = 32'd0;
        end else if (m_valid) begin
            if (m_busy) begin
                if (flush) begin
                    m_busy = 1'b0;
                end else if (m_left == 0) begin
                    m_com_hi = m_pend_hi;
                    m_com_lo = m_pend_lo;
                    m_busy   = 1'b0;
                end else begin
                    m_left--;
                end
            end else if (start && !flush) begin
                golden(op, a, b, m_pend_hi, m_pend_lo, lat);
                m_busy = 1'b1;
                m_left = lat - 1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic e_done, e_stall;
        if (m_valid) begin
            e_done  = m_busy && (m_left == 0) && !flush;
            e_stall = m_busy ? (m_left != 0) : (start && !flush);
            check("model_stall", {31'd0, stall}, {31'd0, e_stall});
            check("model_done",  {31'd0, done},  {31'd0, e_done});
            check("model_hi", hi, e_done ? m_pend_hi : m_com_hi);
            check("model_lo", lo, e_done ? m_pend_lo : m_com_lo);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction and hold start until its done cycle; optionally scramble operands
    task automatic issue(input logic [1:0] o, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] eh, input logic [31:0] el, input int lat, input bit scr);
        int seen;
        seen  = -1;
        start = 1'b1; op = o; a = ia; b = ib;
        for (int c = 0; c <= lat + 3 && seen < 0; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = c;
                check("result_hi", hi, eh);
                check("result_lo", lo, el);
            end else begin
                cyc();
                if (scr) begin
                    a  = $urandom;
                    b  = $urandom;
                    op = 2'($urandom_range(0, 3));
                end
            end
        end
        check("done_latency", 32'(seen), 32'(lat));
        if (seen >= 0) cyc();
        start = 1'b0;
    endtask

    initial begin
        int dones;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        cyc();
        cyc();
        @(negedge clk);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        cyc();
        rst = 1'b0;
        cyc();

        issue(2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 1'b0);
        cyc();
        issue(2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 2, 1'b1);
        cyc();
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b1);
        cyc();
        issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0);
        cyc();
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, 1'b0);
        cyc();
        issue(2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, 1'b0);
        cyc();
        issue(2'b10, 32'h0000_1234, 32'hFFFF_FFF0, 32'h0000_0004, 32'hFFFF_FEDD, 33, 1'b0);
        cyc();

        // Flush mid-divide, then a new multiply the cycle after
        start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
        for (int i = 0; i < 10; i++) cyc();
        flush = 1'b1;
        @(negedge clk);
        check("flush_done", {31'd0, done}, 32'd0);
        check("flush_hi", hi, 32'h0000_0004);
        check("flush_lo", lo, 32'hFFFF_FEDD);
        cyc();
        flush = 1'b0;
        issue(2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 2, 1'b0);

        // Flush in the DONE cycle suppresses the result
        start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        cyc();
        cyc();
        flush = 1'b1;
        @(negedge clk);
        check("flushdone_done", {31'd0, done}, 32'd0);
        check("flushdone_lo", lo, 32'd42);
        cyc();
        flush = 1'b0; start = 1'b0;
        cyc();

        // Back-to-back with start held across DONE into the next instruction
        issue(2'b00, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 2, 1'b0);
        issue(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 33, 1'b0);
        cyc();

        // Reset mid-divide
        start = 1'b1; op = 2'b10; a = 32'd77; b = 32'd5;
        for (int i = 0; i < 5; i++) cyc();
        rst = 1'b1; start = 1'b0;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_stall", {31'd0, stall}, 32'd0);
        check("midrst_done",  {31'd0, done},  32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        cyc();
        issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
